// File: rtl/fft_pkg.sv
// Shared definitions for the radix-4 FFT datapath.
//   FFT_N / FFT_LANES : frame size and number of parallel lanes
//   FFT_DATA_W        : default sample width
//   fft_sample_t      : signed sample type
//   ser_state_t       : read-side FSM state of the output serializer
//   fft_bin_k()       : maps (lane, beat) to the true bin number k = 4*lane + beat
package fft_pkg;

  localparam int unsigned FFT_N      = 16;
  localparam int unsigned FFT_LANES  = 4;
  localparam int unsigned FFT_DATA_W = 32;

  typedef logic signed [FFT_DATA_W-1:0] fft_sample_t;

  typedef enum logic [0:0] {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_t;

  // Digit-reversed radix-4 order: lane is the high digit, beat the low digit.
  function automatic logic [3:0] fft_bin_k(input logic [1:0] lane, input logic [1:0] beat);
    return {lane, beat};
  endfunction

endpackage

// File: rtl/fft_ser_bank.sv
// One half of the serializer ping-pong store: 16 x DATA_W register file with a full flag.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset (clears the full flag only)
//   wr_en, wr_beat    : write all four lanes of beat wr_beat at slots 4*lane + beat
//   wr_data           : packed lane data, index 0 = lane 0
//   set_full/clr_full : mark the bank full (frame complete) / empty (frame drained)
//   rd_addr, rd_data  : asynchronous read port
//   full              : registered full flag
module fft_ser_bank
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                wr_en,
  input  logic [1:0]                          wr_beat,
  input  logic [FFT_LANES-1:0][DATA_W-1:0]    wr_data,
  input  logic                                set_full,
  input  logic                                clr_full,
  input  logic [3:0]                          rd_addr,
  output logic [DATA_W-1:0]                   rd_data,
  output logic                                full
);

  logic [FFT_N-1:0][DATA_W-1:0] mem_q, mem_d;
  logic                         full_q, full_d;

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int l = 0; l < FFT_LANES; l++) begin
        mem_d[fft_bin_k(2'(l), wr_beat)] = wr_data[l];
      end
    end
  end

  // A bank is only ever set while empty and cleared while full, so the two never collide.
  always_comb begin
    full_d = full_q;
    if (clr_full) full_d = 1'b0;
    if (set_full) full_d = 1'b1;
  end

  // Sample storage needs no reset: the full flag gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
    end else begin
      full_q <= full_d;
    end
  end

  assign rd_data = mem_q[rd_addr];
  assign full    = full_q;

endmodule

// File: rtl/fft_output_serializer.sv
// Parallel-to-serial output stage of the 16-point radix-4 FFT.
// Collects four lanes over four beats into a ping-pong pair of banks and streams one bin per
// valid/ready transfer together with its true bin index.
// Ports:
//   clk, reset_n            : clock, asynchronous active-low reset
//   in_0..in_3, in_q_flag   : lane results and beat index of the current group
//   in_valid / in_ready     : input handshake (in_ready combinational from full flags)
//   out_data, out_index     : serial bin value and its bin number k
//   out_valid / out_ready   : output handshake
//   out_last                : 16th bin of the frame
//   frame_err               : one-cycle pulse on a beat-sequence violation
// Build option: FFT_SER_NATURAL_ORDER_EN emits bins in natural order k = 0..15; otherwise
// bins leave in arrival order (beat-major, lane-minor).
module fft_output_serializer
  import fft_pkg::*;
#(
  parameter int unsigned DATA_W = FFT_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] in_0,
  input  logic signed [DATA_W-1:0] in_1,
  input  logic signed [DATA_W-1:0] in_2,
  input  logic signed [DATA_W-1:0] in_3,
  input  logic        [1:0]        in_q_flag,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic        [3:0]        out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     frame_err
);

  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        wq_q, wq_d;
  ser_state_t        state_q, state_d;
  logic [3:0]        rc_q, rc_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [3:0]        out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              frame_err_q, frame_err_d;

  logic              full_a, full_b;
  logic              wr_full, rd_full, oth_full;
  logic              accept, beat_ok, bank_wr, bank_done;
  logic              free, ld, ld_bank;
  logic [3:0]        ld_rc, ld_slot;
  logic [DATA_W-1:0] rd_a, rd_b, ld_data;

  assign wr_full  = wr_ptr_q ? full_b : full_a;
  assign rd_full  = rd_ptr_q ? full_b : full_a;
  assign oth_full = rd_ptr_q ? full_a : full_b;
  assign in_ready = ~wr_full;

  // Write side
  assign accept    = in_valid & in_ready;
  assign beat_ok   = (in_q_flag == wq_q);
  // An out-of-sequence beat 0 restarts the frame and is kept.
  assign bank_wr   = accept & (beat_ok | (in_q_flag == 2'd0));
  assign bank_done = accept & beat_ok & (wq_q == 2'd3);

  always_comb begin
    wq_d        = wq_q;
    frame_err_d = 1'b0;
    wr_ptr_d    = wr_ptr_q ^ bank_done;
    if (accept) begin
      if (beat_ok) begin
        wq_d = wq_q + 2'd1;
      end else begin
        frame_err_d = 1'b1;
        wq_d        = (in_q_flag == 2'd0) ? 2'd1 : 2'd0;
      end
    end
  end

  // Read side: ld loads the output registers with slot ld_rc of bank ld_bank.
  always_comb begin
    state_d     = state_q;
    rc_d        = rc_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    free        = 1'b0;
    ld          = 1'b0;
    ld_bank     = rd_ptr_q;
    ld_rc       = 4'd0;
    case (state_q)
      SER_IDLE: begin
        if (rd_full) begin
          state_d     = SER_STREAM;
          rc_d        = 4'd0;
          out_valid_d = 1'b1;
          ld          = 1'b1;
        end
      end
      SER_STREAM: begin
        if (out_ready) begin
          if (rc_q == 4'd15) begin
            free     = 1'b1;
            rd_ptr_d = ~rd_ptr_q;
            rc_d     = 4'd0;
            if (oth_full) begin
              ld      = 1'b1;
              ld_bank = ~rd_ptr_q;
            end else begin
              state_d     = SER_IDLE;
              out_valid_d = 1'b0;
            end
          end else begin
            rc_d  = rc_q + 4'd1;
            ld    = 1'b1;
            ld_rc = rc_q + 4'd1;
          end
        end
      end
      default: state_d = SER_IDLE;
    endcase
  end

`ifdef FFT_SER_NATURAL_ORDER_EN
  assign ld_slot = ld_rc;
`else
  // rc counts beat-major: high digit is the beat, low digit the lane.
  assign ld_slot = fft_bin_k(ld_rc[1:0], ld_rc[3:2]);
`endif

  assign ld_data = ld_bank ? rd_b : rd_a;

  always_comb begin
    out_data_d  = ld ? ld_data : out_data_q;
    out_index_d = ld ? ld_slot : out_index_q;
    out_last_d  = ld ? (ld_rc == 4'd15) : (out_last_q & out_valid_d);
  end

  fft_ser_bank #(
    .DATA_W (DATA_W)
  ) u_bank_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (bank_wr & ~wr_ptr_q),
    .wr_beat  (in_q_flag),
    .wr_data  ({in_3, in_2, in_1, in_0}),
    .set_full (bank_done & ~wr_ptr_q),
    .clr_full (free & ~rd_ptr_q),
    .rd_addr  (ld_slot),
    .rd_data  (rd_a),
    .full     (full_a)
  );

  fft_ser_bank #(
    .DATA_W (DATA_W)
  ) u_bank_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (bank_wr & wr_ptr_q),
    .wr_beat  (in_q_flag),
    .wr_data  ({in_3, in_2, in_1, in_0}),
    .set_full (bank_done & wr_ptr_q),
    .clr_full (free & rd_ptr_q),
    .rd_addr  (ld_slot),
    .rd_data  (rd_b),
    .full     (full_b)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wq_q        <= 2'd0;
      state_q     <= SER_IDLE;
      rc_q        <= 4'd0;
      out_data_q  <= '0;
      out_index_q <= 4'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      wq_q        <= wq_d;
      state_q     <= state_d;
      rc_q        <= rc_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_err = frame_err_q;

endmodule
